// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory responder
package mem_pkg;

    localparam int          MEM_AWIDTH      = 32;
    localparam logic [31:0] MEM_BASE_ADDR   = 32'h0100_0000;
    localparam int          MEM_DEPTH_WORDS = 1024;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic [MEM_AWIDTH-1:0] addr;
        logic                  we;
        mem_size_e             size;
        logic                  is_unsigned;
        logic [31:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane masks, write steering and read extraction
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {lane, 3'b000};
    assign wword   = wdata << {lane, 3'b000};

    always_comb begin
        be    = 4'b0000;
        rdata = 32'h0;
        case (size)
            MEM_BYTE: begin
                be    = 4'b0001 << lane;
                rdata = {{24{!is_unsigned && shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                be    = 4'b0011 << lane;
                rdata = {{16{!is_unsigned && shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                be    = 4'b1111;
                rdata = rword;
            end
            default: begin
                be    = 4'b0000;
                rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory target with fixed access latency
module mem_responder
    import mem_pkg::*;
#(
    parameter int                AWIDTH      = MEM_AWIDTH,
    parameter int                DWIDTH      = 32,
    parameter int                DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = MEM_BASE_ADDR,
    parameter int                LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int IW = $clog2(DEPTH_WORDS);

    mem_state_e        state;
    logic [3:0]        cnt;
    mem_req_t          req_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] off;
    logic              in_range;
    logic              misaligned;
    logic              err;
    logic              commit;
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       rdata_ext;

    // Decode works only from the latched request, so req_* are don't-care after accept.
    assign addr_q   = AWIDTH'(req_q.addr);
    assign off      = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ((off >> 2) < AWIDTH'(DEPTH_WORDS));
    assign idx      = off[IW+1:2];
    assign lane     = off[1:0];
    assign word     = mem[idx];

    always_comb begin
        misaligned = 1'b0;
        case (req_q.size)
            MEM_HALF: misaligned = lane[0];
            MEM_WORD: misaligned = (lane != 2'b00);
            default:  misaligned = 1'b0;
        endcase
    end

    assign err         = !in_range || misaligned || (req_q.size == MEM_RSVD);
    assign commit      = (state == WAIT) && (cnt == 4'd0);
    assign req_ready_o = (state == IDLE);

    mem_lane_align u_lane_align (
        .size        (req_q.size),
        .lane        (lane),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rword       (word),
        .be          (be),
        .wword       (wword),
        .rdata       (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_q       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q <= '{addr:        MEM_AWIDTH'(req_addr_i),
                                   we:          req_we_i,
                                   size:        mem_size_e'(req_size_i),
                                   is_unsigned: req_unsigned_i,
                                   wdata:       32'(req_wdata_i)};
                        cnt   <= 4'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err;
                        rsp_rdata_o <= (err || req_q.we) ? '0 : DWIDTH'(rdata_ext);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && !err && req_q.we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic rdy_seen);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        lat       = 0;
        rdy_seen  = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        rd        = rsp_rdata;
        er        = rsp_err;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy;
        xact(we, size, uns, addr, wd, rd, er, lat, rdy);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, 32'(er), 32'(exp_err));
        check({tag, ".lat"}, 32'(lat), 32'd2);
        check({tag, ".ready_low"}, 32'(rdy), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_rdata", rsp_rdata, 32'h0);
        check("reset.rsp_err", 32'(rsp_err), 32'd0);

        run("wr_word",   1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run("rd_word",   1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        run("wr_base",   1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'h1122_3344, 32'h0, 1'b0);
        run("wr_byte",   1'b1, 2'b00, 1'b0, 32'h0100_0013, 32'h0000_0080, 32'h0, 1'b0);
        run("rd_sbyte",  1'b0, 2'b00, 1'b0, 32'h0100_0013, 32'h0, 32'hFFFF_FF80, 1'b0);
        run("rd_ubyte",  1'b0, 2'b00, 1'b1, 32'h0100_0013, 32'h0, 32'h0000_0080, 1'b0);
        run("rd_merged", 1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, 32'h8022_3344, 1'b0);
        run("rd_shalf",  1'b0, 2'b01, 1'b0, 32'h0100_0012, 32'h0, 32'hFFFF_8022, 1'b0);
        run("rd_uhalf",  1'b0, 2'b01, 1'b1, 32'h0100_0012, 32'h0, 32'h0000_8022, 1'b0);

        run("wr_w0",     1'b1, 2'b10, 1'b0, 32'h0100_0000, 32'h5566_7788, 32'h0, 1'b0);
        run("mis_half",  1'b0, 2'b01, 1'b0, 32'h0100_0001, 32'h0, 32'h0, 1'b1);
        run("mis_word",  1'b1, 2'b10, 1'b0, 32'h0100_0002, 32'hAAAA_AAAA, 32'h0, 1'b1);
        run("rd_w0",     1'b0, 2'b10, 1'b0, 32'h0100_0000, 32'h0, 32'h5566_7788, 1'b0);
        run("rsvd",      1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0, 32'h0, 1'b1);

        run("oor_low",   1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0, 32'h0, 1'b1);
        run("oor_high",  1'b0, 2'b10, 1'b0, 32'h0100_1000, 32'h0, 32'h0, 1'b1);
        run("last_wr",   1'b1, 2'b10, 1'b0, 32'h0100_0FFC, 32'h0BAD_CAFE, 32'h0, 1'b0);
        run("last_rd",   1'b0, 2'b10, 1'b0, 32'h0100_0FFC, 32'h0, 32'h0BAD_CAFE, 1'b0);

        // Backpressure: response held for 5 cycles while stray requests arrive.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0100_0010;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("bp.valid_rise", 32'(rsp_valid), 32'd1);
        held = rsp_rdata;
        check("bp.rdata", held, 32'h8022_3344);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0];
            req_we    = 1'b1;
            req_addr  = 32'h0100_0010;
            req_wdata = 32'hFFFF_FFFF;
            check("bp.ready_low", 32'(req_ready), 32'd0);
            step();
            check("bp.valid_held", 32'(rsp_valid), 32'd1);
            check("bp.rdata_held", rsp_rdata, 32'h8022_3344);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp.idle_ready", 32'(req_ready), 32'd1);
        check("bp.idle_valid", 32'(rsp_valid), 32'd0);
        repeat (4) step();
        check("bp.no_stray", 32'(rsp_valid), 32'd0);
        run("bp.rd_after", 1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, 32'h8022_3344, 1'b0);

        // Reset during WAIT must cancel the pending write.
        run("rst.pre_wr", 1'b1, 2'b10, 1'b0, 32'h0100_0020, 32'h1234_5678, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0100_0020;
        req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        check("rst.in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.rdata", rsp_rdata, 32'h0);
        run("rst.rd_old", 1'b0, 2'b10, 1'b0, 32'h0100_0020, 32'h0, 32'h1234_5678, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
